// File: rtl/prog_loader_if.sv
// Load-stream and instruction-memory write bus shared by prog_loader and its neighbours.
//   load_valid/load_data/load_last : word stream from the image source
//   load_ready                     : loader accepts the presented word
//   imem_we/imem_addr/imem_wdata   : zero-latency write port into instruction memory
// The slave modport is the loader's view; the master modport is the source/memory side.
interface prog_loader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output load_valid, load_data, load_last,
        input  load_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams an instruction image into memory, then releases the core for a
// programmed number of clocks (or free-runs) before holding it again.
//   clk, reset        : single clock, synchronous active-high reset
//   start_i, abort_i  : single-cycle sequence control; abort wins over start
//   run_cycles_i      : run length sampled on start (0 = free-run until abort)
//   bus_io            : load stream in, imem write port out (prog_loader_if.slave)
//   cpu_hold_o        : core hold, low only while running
//   busy_o, done_o    : LOAD/RUN in progress, sequence finished
//   overflow_err_o    : sticky, image longer than DEPTH words
//   words_loaded_o    : words accepted in the current or last load
module prog_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CNT_W-1:0]  run_cycles_i,
    prog_loader_if.slave      bus_io,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_err_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WlOne    = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);

    state_e             state_q;
    logic               ready_q;
    logic               hold_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic [ADDR_W-1:0]  wptr_q;
    logic [ADDR_W:0]    wl_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   rc_q;
    logic               accept;

    assign accept            = bus_io.load_valid & ready_q;
    assign bus_io.load_ready = ready_q;
    assign bus_io.imem_we    = accept;
    assign bus_io.imem_addr  = wptr_q;
    assign bus_io.imem_wdata = bus_io.load_data;

    assign cpu_hold_o     = hold_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign overflow_err_o = ovf_q;
    assign words_loaded_o = wl_q;

    // Outputs are registered alongside the state so they change exactly on state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            wl_q    <= '0;
            cnt_q   <= '0;
            rc_q    <= '0;
        end else begin
            // An accepted word always counts, even if abort lands in the same cycle.
            if (accept) begin
                wptr_q <= wptr_q + AddrOne;
                wl_q   <= wl_q + WlOne;
            end
            if (accept && !bus_io.load_last && wptr_q == LastAddr) begin
                ovf_q <= 1'b1;
            end

            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i && !abort_i) begin
                        state_q <= StLoad;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        hold_q  <= 1'b1;
                        wptr_q  <= '0;
                        wl_q    <= '0;
                        ovf_q   <= 1'b0;
                        rc_q    <= run_cycles_i;
                    end else if (abort_i && state_q == StDone) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                        hold_q  <= 1'b1;
                    end
                end

                StLoad: begin
                    if (abort_i) begin
                        state_q <= StIdle;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        hold_q  <= 1'b1;
                    end else if (accept) begin
                        if (bus_io.load_last) begin
                            state_q <= StRun;
                            ready_q <= 1'b0;
                            hold_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else if (wptr_q == LastAddr) begin
                            // Memory full and image not finished: never release the core.
                            state_q <= StDone;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                StRun: begin
                    if (abort_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        hold_q  <= 1'b1;
                    end else if (rc_q != '0 && cnt_q == rc_q - CntOne) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        hold_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a DEPTH=256 instance for the main flows and a
// DEPTH=4 instance for image overflow. Expectations come from a simple model of the load
// image (expected write list, run length, word count).
module tb_prog_loader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main instance.
    logic        start, abort;
    logic [15:0] run_cycles;
    logic        cpu_hold, busy, done, ovf;
    logic [8:0]  wl;
    prog_loader_if #(.DATA_W(32), .ADDR_W(8)) bus ();

    prog_loader #(.DATA_W(32), .DEPTH(256), .ADDR_W(8), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start),
        .abort_i        (abort),
        .run_cycles_i   (run_cycles),
        .bus_io         (bus.slave),
        .cpu_hold_o     (cpu_hold),
        .busy_o         (busy),
        .done_o         (done),
        .overflow_err_o (ovf),
        .words_loaded_o (wl)
    );

    // Small instance for overflow.
    logic        s_start, s_abort;
    logic [15:0] s_rc;
    logic        s_hold, s_busy, s_done, s_ovf;
    logic [2:0]  s_wl;
    prog_loader_if #(.DATA_W(32), .ADDR_W(2)) sbus ();

    prog_loader #(.DATA_W(32), .DEPTH(4), .ADDR_W(2), .CNT_W(16)) dut_s (
        .clk            (clk),
        .reset          (reset),
        .start_i        (s_start),
        .abort_i        (s_abort),
        .run_cycles_i   (s_rc),
        .bus_io         (sbus.slave),
        .cpu_hold_o     (s_hold),
        .busy_o         (s_busy),
        .done_o         (s_done),
        .overflow_err_o (s_ovf),
        .words_loaded_o (s_wl)
    );

    // Monitors: record every write strobe and every cycle the core is released.
    logic [39:0] wr_q[$];
    logic [33:0] s_wr_q[$];
    int          low_cnt = 0;
    int          s_low_cnt = 0;
    logic [31:0] img_q[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) wr_q.push_back({bus.imem_addr, bus.imem_wdata});
        if (cpu_hold === 1'b0) low_cnt++;
        if (sbus.imem_we === 1'b1) s_wr_q.push_back({sbus.imem_addr, sbus.imem_wdata});
        if (s_hold === 1'b0) s_low_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a sequence, stream img_q (optionally with random valid gaps), then wait for done.
    // Expected: word i written to address i, core released for exactly rc clocks.
    task automatic run_seq(input logic [15:0] rc, input bit gaps, input bit poke_start,
                           input string tag);
        int n;
        int i;
        int k;
        n = img_q.size();
        wr_q.delete();
        low_cnt = 0;
        start = 1'b1;
        run_cycles = rc;
        step();
        start = 1'b0;
        run_cycles = $urandom;
        i = 0;
        k = 0;
        while (i < n && k < 1000) begin
            bus.load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.load_data  = bus.load_valid ? img_q[i] : $urandom;
            bus.load_last  = bus.load_valid ? (i == n - 1) : 1'($urandom_range(0, 1));
            step();
            if (bus.load_valid) i++;
            k++;
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < int'(rc) + 50) begin
            @(negedge clk);
            start = (poke_start && k == 2);
            k++;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done: got %b want 1 (timeout)", tag, done);
        end
        checks++;
        if (low_cnt != int'(rc)) begin
            failures++;
            $display("FAIL %s run_len: got %0d want %0d", tag, low_cnt, rc);
        end
        checks++;
        if (wl !== 9'(n)) begin
            failures++;
            $display("FAIL %s words_loaded: got %0d want %0d", tag, wl, n);
        end
        checks++;
        if (cpu_hold !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s done_flags: hold=%b busy=%b want 1/0", tag, cpu_hold, busy);
        end
        checks++;
        if (wr_q.size() != n) begin
            failures++;
            $display("FAIL %s write_count: got %0d want %0d", tag, wr_q.size(), n);
        end else begin
            for (int j = 0; j < n; j++) begin
                checks++;
                if (wr_q[j] !== {8'(j), img_q[j]}) begin
                    failures++;
                    $display("FAIL %s write[%0d]: got %h want %h", tag, j, wr_q[j],
                             {8'(j), img_q[j]});
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0; abort = 1'b0; run_cycles = '0;
        s_start = 1'b0; s_abort = 1'b0; s_rc = '0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
        sbus.load_valid = 1'b0; sbus.load_data = '0; sbus.load_last = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({cpu_hold, bus.load_ready, bus.imem_we, done, busy, ovf} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags: hold/ready/we/done/busy/ovf=%b want 100000",
                     {cpu_hold, bus.load_ready, bus.imem_we, done, busy, ovf});
        end
        checks++;
        if (bus.imem_addr !== 8'd0 || wl !== 9'd0) begin
            failures++;
            $display("FAIL reset_counts: addr=%0d wl=%0d want 0/0", bus.imem_addr, wl);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        img_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_seq(16'd44, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_backpressure();
        wr_q.delete();
        start = 1'b1; run_cycles = 16'd2;
        step();
        start = 1'b0;
        bus.load_valid = 1'b1; bus.load_data = 32'hA5A5_0001; bus.load_last = 1'b0;
        step();
        bus.load_valid = 1'b0; bus.load_data = 32'hDEAD_BEEF; bus.load_last = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_we !== 1'b0 || bus.load_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_gap1: we=%b ready=%b want 0/1", bus.imem_we, bus.load_ready);
        end
        step();
        bus.load_valid = 1'b1; bus.load_data = 32'hA5A5_0002; bus.load_last = 1'b1;
        step();
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_we !== 1'b0) begin
            failures++;
            $display("FAIL bp_gap2: we=%b want 0", bus.imem_we);
        end
        repeat (6) step();
        checks++;
        if (wr_q.size() != 2) begin
            failures++;
            $display("FAIL bp_writes: got %0d want 2", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0] !== {8'd0, 32'hA5A5_0001} || wr_q[1] !== {8'd1, 32'hA5A5_0002}) begin
                failures++;
                $display("FAIL bp_data: got %h %h want %h %h", wr_q[0], wr_q[1],
                         {8'd0, 32'hA5A5_0001}, {8'd1, 32'hA5A5_0002});
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int n;
            logic [15:0] rc;
            n  = $urandom_range(1, 12);
            rc = 16'($urandom_range(1, 30));
            img_q.delete();
            for (int j = 0; j < n; j++) img_q.push_back($urandom);
            run_seq(rc, 1'b1, rc >= 16'd8, $sformatf("rand%0d", r));
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d[5];
        s_wr_q.delete();
        s_low_cnt = 0;
        s_start = 1'b1; s_rc = 16'd7;
        step();
        s_start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            d[j] = $urandom;
            sbus.load_valid = 1'b1; sbus.load_data = d[j]; sbus.load_last = 1'b0;
            step();
        end
        sbus.load_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (s_ovf !== 1'b1 || s_done !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flags: ovf=%b done=%b want 1/1", s_ovf, s_done);
        end
        checks++;
        if (s_low_cnt != 0 || s_hold !== 1'b1) begin
            failures++;
            $display("FAIL ovf_hold: low_cycles=%0d hold=%b want 0/1", s_low_cnt, s_hold);
        end
        checks++;
        if (s_wl !== 3'd4 || s_wr_q.size() != 4) begin
            failures++;
            $display("FAIL ovf_count: wl=%0d writes=%0d want 4/4", s_wl, s_wr_q.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (s_wr_q[j] !== {2'(j), d[j]}) begin
                    failures++;
                    $display("FAIL ovf_write[%0d]: got %h want %h", j, s_wr_q[j],
                             {2'(j), d[j]});
                end
            end
        end
    endtask

    task automatic test_abort_run();
        low_cnt = 0;
        start = 1'b1; run_cycles = 16'd0;
        step();
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            bus.load_valid = 1'b1; bus.load_data = $urandom; bus.load_last = (j == 2);
            step();
        end
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        repeat (99) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (low_cnt != 100) begin
            failures++;
            $display("FAIL abort_runlen: got %0d want 100", low_cnt);
        end
        checks++;
        if ({cpu_hold, busy, done, bus.load_ready} !== 4'b1000) begin
            failures++;
            $display("FAIL abort_flags: hold/busy/done/ready=%b want 1000",
                     {cpu_hold, busy, done, bus.load_ready});
        end
        checks++;
        if (wl !== 9'd3) begin
            failures++;
            $display("FAIL abort_wl: got %0d want 3", wl);
        end
    endtask

    task automatic test_start_abort();
        start = 1'b1; abort = 1'b1; run_cycles = 16'd5;
        step();
        start = 1'b0; abort = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.load_ready !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
                failures++;
                $display("FAIL start_abort: ready=%b busy=%b hold=%b want 0/0/1",
                         bus.load_ready, busy, cpu_hold);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1; run_cycles = 16'd9;
        step();
        start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            bus.load_valid = 1'b1; bus.load_data = $urandom; bus.load_last = 1'b0;
            step();
        end
        reset = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if ({cpu_hold, bus.load_ready, bus.imem_we, done, busy, ovf} !== 6'b100000 ||
            bus.imem_addr !== 8'd0 || wl !== 9'd0) begin
            failures++;
            $display("FAIL midload_reset: flags=%b addr=%0d wl=%0d want 100000/0/0",
                     {cpu_hold, bus.load_ready, bus.imem_we, done, busy, ovf},
                     bus.imem_addr, wl);
        end
        bus.load_valid = 1'b0;
        reset = 1'b0;
        step();
        img_q = '{32'hCAFE_0000, 32'hCAFE_0001};
        run_seq(16'd3, 1'b0, 1'b0, "reload");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_overflow();
        test_abort_run();
        test_start_abort();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
